// File: rtl/comb_out_monitor.sv
// comb_out_monitor
//   Watches three asynchronous outputs (x, y, z) of an upstream combinational
//   block. Each bit is synchronized and its toggles are counted. A small FSM
//   raises a one-cycle hit when the synchronized pattern holds MATCH for
//   STABLE_CYC+1 consecutive cycles. Counters are read out over a four-phase
//   req/ack handshake.
//
// Ports
//   clk       rising-edge clock
//   rst_n     async active-low reset
//   x, y, z   asynchronous inputs
//   clr       sync clear of all counters and the match FSM
//   sel       read select: 0=x toggles, 1=y toggles, 2=z toggles, 3=hits
//   rd_req    four-phase read request
//   rd_ack    four-phase read acknowledge
//   rd_data   captured counter, valid while rd_ack is high
//   xyz_sync  synchronized {x,y,z}
//   match     one-cycle hit pulse

// Per-bit lane: 2-flop synchronizer, previous-value flop and a saturating
// toggle counter.
module comb_out_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din,
  output logic             sync,
  output logic [CNT_W-1:0] cnt
);
  logic [1:0] sync_pipe;
  logic       prev;
  logic       tog;

  assign sync = sync_pipe[1];
  assign tog  = sync ^ prev;

  // clr leaves the synchronizer and the previous-value flop alone so no
  // toggle is lost or invented around a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      prev      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], din};
      prev      <= sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (tog && (cnt != '1))     cnt <= cnt + 1'b1;
  end
endmodule

module comb_out_monitor #(
  parameter int         CNT_W      = 8,
  parameter int         STABLE_CYC = 4,
  parameter logic [2:0] MATCH      = 3'b101
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic             clr,
  input  logic [1:0]       sel,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic [2:0]       xyz_sync,
  output logic             match
);
  localparam int        NUM_LANES = 3;
  localparam logic [3:0] STAB_TGT = 4'(STABLE_CYC);

  typedef enum logic [1:0] {IDLE, QUAL, HIT, HOLD} state_t;

  logic [2:0]                      xyz_in;
  logic [NUM_LANES-1:0][CNT_W-1:0] tog_cnt;
  logic [CNT_W-1:0]                hit_cnt;
  logic [CNT_W-1:0]                rd_mux;
  state_t                          state_q, state_d;
  logic [3:0]                      stab_q, stab_d;
  logic                            is_pat;

  // Lane i carries bit i of {x,y,z}: lane 2 = x, lane 1 = y, lane 0 = z.
  assign xyz_in = {x, y, z};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    comb_out_lane #(.CNT_W(CNT_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .din  (xyz_in[i]),
      .sync (xyz_sync[i]),
      .cnt  (tog_cnt[i])
    );
  end

  // ---------------------------------------------------------------- match FSM
  assign is_pat = (xyz_sync == MATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    unique case (state_q)
      IDLE: if (is_pat) begin
        state_d = QUAL;
        stab_d  = 4'd1;
      end
      QUAL: begin
        if (!is_pat)                state_d = IDLE;
        else if (stab_q == STAB_TGT) state_d = HIT;
        else                        stab_d  = stab_q + 4'd1;
      end
      HIT:  state_d = is_pat ? HOLD : IDLE;
      HOLD: if (!is_pat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      stab_d  = '0;
    end
  end

  // A clear landing in HIT suppresses the pulse as well as the count.
  assign match = (state_q == HIT) && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  hit_cnt <= '0;
    else if (clr)                                hit_cnt <= '0;
    else if ((state_q == HIT) && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
  end

  // ------------------------------------------------------------ read handshake
  // Mux reads the registered counters, so a same-cycle increment is not seen.
  always_comb begin
    rd_mux = hit_cnt;
    unique case (sel)
      2'd0: rd_mux = tog_cnt[2];
      2'd1: rd_mux = tog_cnt[1];
      2'd2: rd_mux = tog_cnt[0];
      2'd3: rd_mux = hit_cnt;
      default: rd_mux = hit_cnt;
    endcase
  end

  // Capture only on the req-rise phase; rd_data is frozen for the rest of the
  // handshake regardless of sel or clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else if (rd_req && !rd_ack) begin
      rd_ack  <= 1'b1;
      rd_data <= rd_mux;
    end else if (!rd_req && rd_ack) begin
      rd_ack  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_comb_out_monitor.sv
module tb_comb_out_monitor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       x = 1'b0, y = 1'b0, z = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       rd_req = 1'b0;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic [2:0] xyz_sync;
  logic       match;

  int tests = 0;
  int fails = 0;

  comb_out_monitor #(.CNT_W(8), .STABLE_CYC(4), .MATCH(3'b101)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z), .clr(clr), .sel(sel),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .xyz_sync(xyz_sync), .match(match)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [1:0] s, input logic [7:0] exp, input string tag);
    sel = s;
    rd_req = 1'b1;
    chk({tag, "_ack_lo"}, 32'(rd_ack), 32'd0);
    tick;
    chk({tag, "_ack_hi"}, 32'(rd_ack), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    rd_req = 1'b0;
    tick;
    chk({tag, "_ack_fall"}, 32'(rd_ack), 32'd0);
  endtask

  task automatic clr_pulse;
    clr = 1'b1;
    tick;
    clr = 1'b0;
  endtask

  int pulses;
  int pulse_at;

  initial begin
    // Reset with x already high
    x = 1'b1;
    #2 rst_n = 1'b0;
    tick;
    tick;
    chk("rst_ack", 32'(rd_ack), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_sync", 32'(xyz_sync), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    rst_n = 1'b1;
    tick;
    chk("sync_lat1", 32'(xyz_sync), 32'd0);
    tick;
    chk("sync_lat2", 32'(xyz_sync), 32'b100);
    tick;
    tick;
    do_read(2'd0, 8'd1, "x_tog_rel");
    do_read(2'd1, 8'd0, "y_tog_rel");

    // sel change while ack high must not disturb rd_data
    sel = 2'd0;
    rd_req = 1'b1;
    tick;
    chk("selhold_d0", 32'(rd_data), 32'd1);
    sel = 2'd1;
    tick;
    chk("selhold_d1", 32'(rd_data), 32'd1);
    chk("selhold_ack", 32'(rd_ack), 32'd1);
    rd_req = 1'b0;
    tick;
    chk("selhold_fall", 32'(rd_ack), 32'd0);

    // 101 held 10 cycles: one pulse, 7 ticks after driving (2 sync + 5)
    clr_pulse;
    {x, y, z} = 3'b101;
    tick;
    tick;
    chk("pat_sync", 32'(xyz_sync), 32'b101);
    pulses = 0;
    pulse_at = -1;
    for (int n = 3; n <= 20; n++) begin
      if (n == 11) {x, y, z} = 3'b000;
      tick;
      if (match === 1'b1) begin
        pulses++;
        pulse_at = n;
      end
    end
    chk("hit_pulses", 32'(pulses), 32'd1);
    chk("hit_time", 32'(pulse_at), 32'd7);
    do_read(2'd3, 8'd1, "hit_cnt1");
    do_read(2'd2, 8'd2, "z_tog2");
    do_read(2'd0, 8'd1, "x_tog1");

    // 101 for only 3 cycles: no hit
    clr_pulse;
    {x, y, z} = 3'b101;
    tick;
    tick;
    tick;
    {x, y, z} = 3'b000;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      tick;
      if (match === 1'b1) pulses++;
    end
    chk("short_pulses", 32'(pulses), 32'd0);
    do_read(2'd3, 8'd0, "short_hit");

    // 300 toggles of x saturate at 255
    clr_pulse;
    for (int n = 0; n < 300; n++) begin
      x = ~x;
      tick;
    end
    tick;
    tick;
    tick;
    do_read(2'd0, 8'd255, "x_sat");
    do_read(2'd1, 8'd0, "y_nosat");

    // clr lands exactly in the QUAL cycle that would go to HIT; held one more
    // cycle to also swallow the toggles of the pattern leaving
    clr_pulse;
    {x, y, z} = 3'b101;
    for (int n = 1; n <= 5; n++) tick;
    {x, y, z} = 3'b000;
    tick;
    chk("clrhit_pre", 32'(match), 32'd0);
    clr = 1'b1;
    tick;
    chk("clrhit_clr", 32'(match), 32'd0);
    tick;
    clr = 1'b0;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      if (match === 1'b1) pulses++;
      tick;
    end
    chk("clrhit_pulses", 32'(pulses), 32'd0);
    do_read(2'd3, 8'd0, "clrhit_hit");
    do_read(2'd0, 8'd0, "clrhit_x");
    do_read(2'd1, 8'd0, "clrhit_y");
    do_read(2'd2, 8'd0, "clrhit_z");

    // Reset mid-handshake with rd_req held high
    sel = 2'd3;
    rd_req = 1'b1;
    tick;
    chk("mid_ack_hi", 32'(rd_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ack_async", 32'(rd_ack), 32'd0);
    chk("mid_data_async", 32'(rd_data), 32'd0);
    tick;
    rst_n = 1'b1;
    chk("mid_ack_rel", 32'(rd_ack), 32'd0);
    tick;
    chk("mid_ack_again", 32'(rd_ack), 32'd1);
    chk("mid_data_again", 32'(rd_data), 32'd0);
    rd_req = 1'b0;
    tick;
    chk("mid_ack_fall", 32'(rd_ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/comb_out_monitor.md
COMB_OUT_MONITOR -- requirements
Module: comb_out_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of every event counter and of rd_data.
REQ-002 Parameter STABLE_CYC, default 4: consecutive cycles the synchronized pattern must equal MATCH before a hit is declared (legal range 1..15).
REQ-003 Parameter MATCH, default 3'b101: target {x,y,z} pattern.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset; assertion clears state immediately; release is synchronous to clk.
REQ-006 x, y, z  in  1 each  outputs of the upstream combinational block; asynchronous to clk.
REQ-007 clr  in  1  synchronous clear of counters and match FSM.
REQ-008 sel  in  2  read select: 0 = x toggles, 1 = y toggles, 2 = z toggles, 3 = hit count.
REQ-009 rd_req  in  1  four-phase read request.
REQ-010 rd_ack  out  1  four-phase read acknowledge.
REQ-011 rd_data  out  CNT_W  captured counter value; valid while rd_ack is high.
REQ-012 xyz_sync  out  3  synchronized {x,y,z}.
REQ-013 match  out  1  one-cycle hit pulse.

Function
REQ-014 Each of x, y, z SHALL pass through a two-flop synchronizer; xyz_sync reflects an input change 2 cycles later.
REQ-015 A toggle SHALL be counted when a bit of xyz_sync differs from its value on the previous cycle; the previous-value register resets to 0.
REQ-016 Toggle and hit counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 Match FSM states: IDLE, QUAL, HIT, HOLD; a stable counter (4 bits) runs in QUAL only.
REQ-018 IDLE -> QUAL when xyz_sync == MATCH, stable counter loaded with 1; otherwise stay IDLE.
REQ-019 QUAL: if xyz_sync != MATCH -> IDLE; else if stable counter == STABLE_CYC -> HIT; else increment.
REQ-020 HIT lasts exactly one cycle, match = 1, hit counter increments; then -> HOLD if xyz_sync == MATCH, else IDLE.
REQ-021 HOLD -> IDLE when xyz_sync != MATCH; no further hit until the pattern leaves and requalifies.
REQ-022 match SHALL be high only in HIT.
REQ-023 Read: when rd_req = 1 and rd_ack = 0, rd_data SHALL capture the sel-selected counter and rd_ack SHALL rise on the next cycle.
REQ-024 rd_ack SHALL stay high, and rd_data held, until rd_req falls; rd_ack falls one cycle after rd_req is seen low.
REQ-025 sel changes while rd_ack = 1 SHALL have no effect on rd_data.
REQ-026 clr = 1 SHALL zero all four counters and force the FSM to IDLE next cycle; clr takes priority over a simultaneous increment or hit; a hit is not reported that cycle.
REQ-027 clr SHALL NOT affect the synchronizers, the read handshake, or rd_data.
REQ-028 A counter read in the same cycle it increments SHALL return the pre-increment value.

Reset
REQ-029 While rst_n = 0: synchronizers, previous-value register, all counters, rd_data = 0; rd_ack = 0, match = 0, FSM = IDLE.
REQ-030 Reset asserted mid-handshake SHALL drop rd_ack immediately; after release, a still-high rd_req starts a new read.
REQ-031 An input already high at reset release SHALL register one toggle once it reaches xyz_sync.

Verification
REQ-032 Reset, x=1,y=0,z=0 held; read sel=0 -> rd_data = 1, rd_ack rises 1 cycle after rd_req; sel=1 -> 0.
REQ-033 Drive {x,y,z}=101 for 10 cycles, then 000 -> exactly one match pulse, STABLE_CYC+1 cycles after 101 reaches xyz_sync; sel=3 read = 1.
REQ-034 Drive 101 for 3 cycles then 000 (STABLE_CYC=4) -> no match; hit count remains 0.
REQ-035 Toggle x 300 times (CNT_W=8) -> sel=0 read = 255.
REQ-036 Pulse clr the same cycle FSM would enter HIT -> match stays 0, all reads = 0.
REQ-037 Assert rst_n=0 while rd_ack=1 with rd_req held high -> rd_ack=0 at once; after release rd_ack returns after one cycle with rd_data = 0.
